// File: rtl/writeback_commit_wb_pkg.sv
// Shared constants and types for the writeback commit stage: flag bit positions,
// datasize encodings, FSM encodings and the latched write-enable bundle.
package writeback_commit_wb_pkg;

    localparam int unsigned FlagCf = 0;
    localparam int unsigned FlagAf = 4;
    localparam int unsigned FlagZf = 6;
    localparam int unsigned FlagDf = 10;

    typedef enum logic [1:0] {
        Size8  = 2'd0,
        Size16 = 2'd1,
        Size32 = 2'd2,
        Size64 = 2'd3
    } datasize_e;

    typedef enum logic {
        StRun,
        StWaitDc
    } dc_state_e;

    typedef enum logic {
        StRepIdle,
        StRepActive
    } rep_state_e;

    typedef struct packed {
        logic gpr1;
        logic gpr2;
        logic gpr3;
        logic seg;
        logic mm;
        logic flags;
        logic dcache;
    } wb_ld_t;

    // A REPNE iteration ends when the compare matched (ZF) or the count ran out.
    function automatic logic repne_done(input logic zf, input logic [31:0] count);
        return zf | (count == 32'd0);
    endfunction

endpackage

// File: rtl/repne_state_wb.sv
// REPNE iteration tracker: holds the loop-active state and the count saved on
// each committed CMPS second half, and flags the commit that ends the loop.
module repne_state_wb
    import writeback_commit_wb_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        commit_i,
    input  logic        repne_i,
    input  logic        cmps_second_i,
    input  logic        zf_i,
    input  logic [31:0] count_i,
    output logic        terminate_o,
    output logic        active_o,
    output logic [31:0] saved_count_o
);

    rep_state_e  state_q, state_d;
    logic [31:0] saved_q, saved_d;
    logic        rep_commit;
    logic        term;

    assign rep_commit = commit_i & repne_i & cmps_second_i;
    assign term       = rep_commit & repne_done(zf_i, count_i);

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        if (rep_commit) begin
            saved_d = count_i;
        end
        unique case (state_q)
            StRepIdle: begin
                if (rep_commit && !term) begin
                    state_d = StRepActive;
                end
            end
            StRepActive: begin
                if (term) begin
                    state_d = StRepIdle;
                end
            end
            default: state_d = StRepIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= StRepIdle;
            saved_q <= 32'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
        end
    end

    assign terminate_o   = term;
    assign active_o      = (state_q == StRepActive);
    assign saved_count_o = saved_q;

endmodule

// File: rtl/writeback_commit_wb.sv
// Writeback commit stage: latches the EX->WB bundle, runs the dcache write
// handshake and commits all architectural writes of an entry in one cycle.
module writeback_commit_wb
    import writeback_commit_wb_pkg::*;
#(
    parameter int unsigned REG_ID_W = 3
) (
    input  logic                CLK,
    input  logic                CLR,

    input  logic                WB_V_next,
    input  logic [31:0]         WB_RESULT_A_next,
    input  logic [31:0]         WB_RESULT_B_next,
    input  logic [31:0]         WB_RESULT_C_next,
    input  logic [31:0]         WB_FLAGS_next,
    input  logic [63:0]         WB_RESULT_MM_next,
    input  logic                WB_LD_GPR1_next,
    input  logic                WB_LD_GPR2_next,
    input  logic                WB_LD_GPR3_next,
    input  logic                WB_LD_SEG_next,
    input  logic                WB_LD_MM_next,
    input  logic                WB_LD_FLAGS_next,
    input  logic                WB_DCACHE_WRITE_next,
    input  logic [REG_ID_W-1:0] WB_DR1_next,
    input  logic [REG_ID_W-1:0] WB_DR2_next,
    input  logic [REG_ID_W-1:0] WB_DR3_next,
    input  logic [REG_ID_W-1:0] WB_SEG_DR_next,
    input  logic [REG_ID_W-1:0] WB_MM_DR_next,
    input  logic [31:0]         WB_MEM_ADDR_next,
    input  logic [1:0]          WB_DATASIZE_next,
    input  logic                WB_de_repne_all_next,
    input  logic                WB_IS_CMPS_SECOND_next,

    input  logic                DC_WR_ACK,

    output logic                WB_Stall,
    output logic                GPR1_WE,
    output logic [REG_ID_W-1:0] GPR1_ID,
    output logic [31:0]         GPR1_DATA,
    output logic                GPR2_WE,
    output logic [REG_ID_W-1:0] GPR2_ID,
    output logic [31:0]         GPR2_DATA,
    output logic                GPR3_WE,
    output logic [REG_ID_W-1:0] GPR3_ID,
    output logic [31:0]         GPR3_DATA,
    output logic                SEG_WE,
    output logic [REG_ID_W-1:0] SEG_ID,
    output logic [15:0]         SEG_DATA,
    output logic                MM_WE,
    output logic [REG_ID_W-1:0] MM_ID,
    output logic [63:0]         MM_DATA,
    output logic                FLAGS_WE,
    output logic [31:0]         FLAGS_DATA,
    output logic                DC_WR_REQ,
    output logic [31:0]         DC_WR_ADDR,
    output logic [31:0]         DC_WR_DATA,
    output logic [1:0]          DC_WR_SIZE,
    output logic                wb_repne_terminate_all,
    output logic [31:0]         saved_count,
    output logic                CS_REPNE_INTERNAL_COUNT_WB,
    output logic [31:0]         RETIRED_COUNT
);

    logic                v_q, v_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [31:0]         c_q, c_d;
    logic [31:0]         flags_q, flags_d;
    logic [63:0]         mm_q, mm_d;
    wb_ld_t              ld_q, ld_d;
    logic [REG_ID_W-1:0] dr1_q, dr1_d;
    logic [REG_ID_W-1:0] dr2_q, dr2_d;
    logic [REG_ID_W-1:0] dr3_q, dr3_d;
    logic [REG_ID_W-1:0] seg_dr_q, seg_dr_d;
    logic [REG_ID_W-1:0] mm_dr_q, mm_dr_d;
    logic [31:0]         addr_q, addr_d;
    datasize_e           size_q, size_d;
    logic                repne_q, repne_d;
    logic                cmps2_q, cmps2_d;

    dc_state_e           dc_state_q, dc_state_d;
    logic [31:0]         retired_q, retired_d;

    logic                need_mem;
    logic                commit;
    logic                stall;

    assign need_mem = v_q & ld_q.dcache;
    assign stall    = need_mem & ~DC_WR_ACK;
    assign commit   = v_q & (~ld_q.dcache | DC_WR_ACK);

    // The latch only advances when the current entry is not waiting on the dcache.
    always_comb begin
        v_d      = v_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        flags_d  = flags_q;
        mm_d     = mm_q;
        ld_d     = ld_q;
        dr1_d    = dr1_q;
        dr2_d    = dr2_q;
        dr3_d    = dr3_q;
        seg_dr_d = seg_dr_q;
        mm_dr_d  = mm_dr_q;
        addr_d   = addr_q;
        size_d   = size_q;
        repne_d  = repne_q;
        cmps2_d  = cmps2_q;
        if (!stall) begin
            v_d      = WB_V_next;
            a_d      = WB_RESULT_A_next;
            b_d      = WB_RESULT_B_next;
            c_d      = WB_RESULT_C_next;
            flags_d  = WB_FLAGS_next;
            mm_d     = WB_RESULT_MM_next;
            ld_d     = '{gpr1:   WB_LD_GPR1_next,
                         gpr2:   WB_LD_GPR2_next,
                         gpr3:   WB_LD_GPR3_next,
                         seg:    WB_LD_SEG_next,
                         mm:     WB_LD_MM_next,
                         flags:  WB_LD_FLAGS_next,
                         dcache: WB_DCACHE_WRITE_next};
            dr1_d    = WB_DR1_next;
            dr2_d    = WB_DR2_next;
            dr3_d    = WB_DR3_next;
            seg_dr_d = WB_SEG_DR_next;
            mm_dr_d  = WB_MM_DR_next;
            addr_d   = WB_MEM_ADDR_next;
            size_d   = datasize_e'(WB_DATASIZE_next);
            repne_d  = WB_de_repne_all_next;
            cmps2_d  = WB_IS_CMPS_SECOND_next;
        end
    end

    always_comb begin
        dc_state_d = dc_state_q;
        unique case (dc_state_q)
            StRun: begin
                if (need_mem && !DC_WR_ACK) begin
                    dc_state_d = StWaitDc;
                end
            end
            StWaitDc: begin
                if (DC_WR_ACK) begin
                    dc_state_d = StRun;
                end
            end
            default: dc_state_d = StRun;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (commit) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            v_q        <= 1'b0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            c_q        <= 32'd0;
            flags_q    <= 32'd0;
            mm_q       <= 64'd0;
            ld_q       <= '0;
            dr1_q      <= '0;
            dr2_q      <= '0;
            dr3_q      <= '0;
            seg_dr_q   <= '0;
            mm_dr_q    <= '0;
            addr_q     <= 32'd0;
            size_q     <= Size8;
            repne_q    <= 1'b0;
            cmps2_q    <= 1'b0;
            dc_state_q <= StRun;
            retired_q  <= 32'd0;
        end else begin
            v_q        <= v_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            flags_q    <= flags_d;
            mm_q       <= mm_d;
            ld_q       <= ld_d;
            dr1_q      <= dr1_d;
            dr2_q      <= dr2_d;
            dr3_q      <= dr3_d;
            seg_dr_q   <= seg_dr_d;
            mm_dr_q    <= mm_dr_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            repne_q    <= repne_d;
            cmps2_q    <= cmps2_d;
            dc_state_q <= dc_state_d;
            retired_q  <= retired_d;
        end
    end

    repne_state_wb u_repne_state_wb (
        .clk_i         (CLK),
        .clr_i         (CLR),
        .commit_i      (commit),
        .repne_i       (repne_q),
        .cmps_second_i (cmps2_q),
        .zf_i          (flags_q[FlagZf]),
        .count_i       (c_q),
        .terminate_o   (wb_repne_terminate_all),
        .active_o      (CS_REPNE_INTERNAL_COUNT_WB),
        .saved_count_o (saved_count)
    );

    assign WB_Stall   = stall;

    assign GPR1_WE    = commit & ld_q.gpr1;
    assign GPR1_ID    = dr1_q;
    assign GPR1_DATA  = a_q;
    assign GPR2_WE    = commit & ld_q.gpr2;
    assign GPR2_ID    = dr2_q;
    assign GPR2_DATA  = b_q;
    assign GPR3_WE    = commit & ld_q.gpr3;
    assign GPR3_ID    = dr3_q;
    assign GPR3_DATA  = c_q;
    assign SEG_WE     = commit & ld_q.seg;
    assign SEG_ID     = seg_dr_q;
    assign SEG_DATA   = a_q[15:0];
    assign MM_WE      = commit & ld_q.mm;
    assign MM_ID      = mm_dr_q;
    assign MM_DATA    = mm_q;
    assign FLAGS_WE   = commit & ld_q.flags;
    assign FLAGS_DATA = flags_q;

    assign DC_WR_REQ  = need_mem;
    assign DC_WR_ADDR = addr_q;
    assign DC_WR_DATA = a_q;
    assign DC_WR_SIZE = size_q;

    assign RETIRED_COUNT = retired_q;

endmodule

// File: tb/tb_writeback_commit_wb.sv
// Scoreboard bench for writeback_commit_wb: stimulus pushes expected commits,
// a negedge monitor pops and compares whenever any write enable fires.
module tb_writeback_commit_wb;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        WB_V_next;
    logic [31:0] WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next, WB_FLAGS_next;
    logic [63:0] WB_RESULT_MM_next;
    logic        WB_LD_GPR1_next, WB_LD_GPR2_next, WB_LD_GPR3_next, WB_LD_SEG_next;
    logic        WB_LD_MM_next, WB_LD_FLAGS_next, WB_DCACHE_WRITE_next;
    logic [2:0]  WB_DR1_next, WB_DR2_next, WB_DR3_next, WB_SEG_DR_next, WB_MM_DR_next;
    logic [31:0] WB_MEM_ADDR_next;
    logic [1:0]  WB_DATASIZE_next;
    logic        WB_de_repne_all_next, WB_IS_CMPS_SECOND_next;
    logic        DC_WR_ACK;

    logic        WB_Stall;
    logic        GPR1_WE, GPR2_WE, GPR3_WE, SEG_WE, MM_WE, FLAGS_WE;
    logic [2:0]  GPR1_ID, GPR2_ID, GPR3_ID, SEG_ID, MM_ID;
    logic [31:0] GPR1_DATA, GPR2_DATA, GPR3_DATA, FLAGS_DATA;
    logic [15:0] SEG_DATA;
    logic [63:0] MM_DATA;
    logic        DC_WR_REQ;
    logic [31:0] DC_WR_ADDR, DC_WR_DATA;
    logic [1:0]  DC_WR_SIZE;
    logic        wb_repne_terminate_all;
    logic [31:0] saved_count;
    logic        CS_REPNE_INTERNAL_COUNT_WB;
    logic [31:0] RETIRED_COUNT;

    writeback_commit_wb #(.REG_ID_W(3)) dut (
        .CLK(CLK), .CLR(CLR),
        .WB_V_next(WB_V_next),
        .WB_RESULT_A_next(WB_RESULT_A_next), .WB_RESULT_B_next(WB_RESULT_B_next),
        .WB_RESULT_C_next(WB_RESULT_C_next), .WB_FLAGS_next(WB_FLAGS_next),
        .WB_RESULT_MM_next(WB_RESULT_MM_next),
        .WB_LD_GPR1_next(WB_LD_GPR1_next), .WB_LD_GPR2_next(WB_LD_GPR2_next),
        .WB_LD_GPR3_next(WB_LD_GPR3_next), .WB_LD_SEG_next(WB_LD_SEG_next),
        .WB_LD_MM_next(WB_LD_MM_next), .WB_LD_FLAGS_next(WB_LD_FLAGS_next),
        .WB_DCACHE_WRITE_next(WB_DCACHE_WRITE_next),
        .WB_DR1_next(WB_DR1_next), .WB_DR2_next(WB_DR2_next), .WB_DR3_next(WB_DR3_next),
        .WB_SEG_DR_next(WB_SEG_DR_next), .WB_MM_DR_next(WB_MM_DR_next),
        .WB_MEM_ADDR_next(WB_MEM_ADDR_next), .WB_DATASIZE_next(WB_DATASIZE_next),
        .WB_de_repne_all_next(WB_de_repne_all_next),
        .WB_IS_CMPS_SECOND_next(WB_IS_CMPS_SECOND_next),
        .DC_WR_ACK(DC_WR_ACK),
        .WB_Stall(WB_Stall),
        .GPR1_WE(GPR1_WE), .GPR1_ID(GPR1_ID), .GPR1_DATA(GPR1_DATA),
        .GPR2_WE(GPR2_WE), .GPR2_ID(GPR2_ID), .GPR2_DATA(GPR2_DATA),
        .GPR3_WE(GPR3_WE), .GPR3_ID(GPR3_ID), .GPR3_DATA(GPR3_DATA),
        .SEG_WE(SEG_WE), .SEG_ID(SEG_ID), .SEG_DATA(SEG_DATA),
        .MM_WE(MM_WE), .MM_ID(MM_ID), .MM_DATA(MM_DATA),
        .FLAGS_WE(FLAGS_WE), .FLAGS_DATA(FLAGS_DATA),
        .DC_WR_REQ(DC_WR_REQ), .DC_WR_ADDR(DC_WR_ADDR), .DC_WR_DATA(DC_WR_DATA),
        .DC_WR_SIZE(DC_WR_SIZE),
        .wb_repne_terminate_all(wb_repne_terminate_all),
        .saved_count(saved_count),
        .CS_REPNE_INTERNAL_COUNT_WB(CS_REPNE_INTERNAL_COUNT_WB),
        .RETIRED_COUNT(RETIRED_COUNT)
    );

    always #5 CLK = ~CLK;

    // ld bit order: gpr1, gpr2, gpr3, seg, mm, flags, dcache
    typedef struct {
        logic        v;
        logic [6:0]  ld;
        logic [2:0]  d1, d2, d3, sd, md;
        logic [31:0] a, b, c, fl, addr;
        logic [63:0] mm;
        logic [1:0]  size;
        logic        repne, cmps2;
    } uop_t;

    typedef struct {
        logic [5:0]  we;
        logic [2:0]  d1, d2, d3, sd, md;
        logic [31:0] a, b, c, fl, ret;
        logic [63:0] mm;
        logic        term;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_retired = 0;
    logic        mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic apply(input uop_t u);
        WB_V_next              = u.v;
        {WB_LD_GPR1_next, WB_LD_GPR2_next, WB_LD_GPR3_next, WB_LD_SEG_next,
         WB_LD_MM_next, WB_LD_FLAGS_next, WB_DCACHE_WRITE_next} = u.ld;
        WB_DR1_next            = u.d1;
        WB_DR2_next            = u.d2;
        WB_DR3_next            = u.d3;
        WB_SEG_DR_next         = u.sd;
        WB_MM_DR_next          = u.md;
        WB_RESULT_A_next       = u.a;
        WB_RESULT_B_next       = u.b;
        WB_RESULT_C_next       = u.c;
        WB_FLAGS_next          = u.fl;
        WB_RESULT_MM_next      = u.mm;
        WB_MEM_ADDR_next       = u.addr;
        WB_DATASIZE_next       = u.size;
        WB_de_repne_all_next   = u.repne;
        WB_IS_CMPS_SECOND_next = u.cmps2;
    endtask

    // Present one uop for a single cycle; returns at posedge+1 of its commit cycle.
    task automatic drive(input uop_t u);
        uop_t z;
        z = '{default: '0};
        apply(u);
        @(posedge CLK);
        #1;
        apply(z);
    endtask

    task automatic push(input uop_t u, input logic term);
        exp_t e;
        e.we   = u.ld[6:1];
        e.d1   = u.d1; e.d2 = u.d2; e.d3 = u.d3; e.sd = u.sd; e.md = u.md;
        e.a    = u.a; e.b = u.b; e.c = u.c; e.fl = u.fl; e.mm = u.mm;
        e.term = term;
        e.ret  = exp_retired;
        exp_retired++;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        logic [5:0] act_we;
        exp_t       e;
        act_we = {GPR1_WE, GPR2_WE, GPR3_WE, SEG_WE, MM_WE, FLAGS_WE};
        if (mon_en && ((|act_we) || wb_repne_terminate_all)) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", {57'd0, wb_repne_terminate_all, act_we}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("we", {58'd0, act_we}, {58'd0, e.we});
                chk("ids", {49'd0, GPR1_ID, GPR2_ID, GPR3_ID, SEG_ID, MM_ID},
                    {49'd0, e.d1, e.d2, e.d3, e.sd, e.md});
                chk("gpr1_gpr2_data", {GPR1_DATA, GPR2_DATA}, {e.a, e.b});
                chk("gpr3_flags_data", {GPR3_DATA, FLAGS_DATA}, {e.c, e.fl});
                chk("seg_data", {48'd0, SEG_DATA}, {48'd0, e.a[15:0]});
                chk("mm_data", MM_DATA, e.mm);
                chk("terminate", {63'd0, wb_repne_terminate_all}, {63'd0, e.term});
                chk("retired_at_commit", {32'd0, RETIRED_COUNT}, {32'd0, e.ret});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        uop_t u;
        u = '{default: '0};
        apply(u);
        DC_WR_ACK = 1'b0;
        CLR = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        CLR = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("rst_stall", {63'd0, WB_Stall}, 64'd0);
        chk("rst_req", {63'd0, DC_WR_REQ}, 64'd0);
        chk("rst_we", {58'd0, GPR1_WE, GPR2_WE, GPR3_WE, SEG_WE, MM_WE, FLAGS_WE}, 64'd0);
        chk("rst_term", {63'd0, wb_repne_terminate_all}, 64'd0);
        chk("rst_retired", {32'd0, RETIRED_COUNT}, 64'd0);
        chk("rst_saved", {32'd0, saved_count}, 64'd0);
        chk("rst_rep_active", {63'd0, CS_REPNE_INTERNAL_COUNT_WB}, 64'd0);

        // ALU uop: GPR1 id 3 <- 0x1234, visible one cycle later
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b1000000; u.d1 = 3'd3; u.a = 32'h1234;
        push(u, 1'b0);
        drive(u);
        chk("alu_gpr1_we", {63'd0, GPR1_WE}, 64'd1);
        chk("alu_no_stall", {63'd0, WB_Stall}, 64'd0);
        step();

        // Back-to-back: multi-target uop then GPR1+GPR2
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b0011110; u.d3 = 3'd5; u.sd = 3'd2; u.md = 3'd7;
        u.a = 32'hCAFE5A5A; u.c = 32'h77; u.fl = 32'h8C5; u.mm = 64'h0123456789ABCDEF;
        push(u, 1'b0);
        drive(u);
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b1100000; u.d1 = 3'd1; u.d2 = 3'd6; u.a = 32'd1; u.b = 32'd2;
        push(u, 1'b0);
        drive(u);
        step();

        // Dcache write with ACK three cycles late, paired GPR2 write
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b0100001; u.d2 = 3'd4; u.b = 32'h55;
        u.a = 32'hDEADBEEF; u.addr = 32'h1000; u.size = 2'd2;
        push(u, 1'b0);
        drive(u);
        for (int k = 0; k < 3; k++) begin
            chk("mem_stall", {63'd0, WB_Stall}, 64'd1);
            chk("mem_req", {63'd0, DC_WR_REQ}, 64'd1);
            chk("mem_fields", {DC_WR_ADDR, DC_WR_DATA}, {32'h1000, 32'hDEADBEEF});
            chk("mem_size", {62'd0, DC_WR_SIZE}, 64'd2);
            chk("mem_gpr2_held", {63'd0, GPR2_WE}, 64'd0);
            step();
        end
        DC_WR_ACK = 1'b1;
        #1;
        chk("ack_stall", {63'd0, WB_Stall}, 64'd0);
        chk("ack_gpr2_we", {63'd0, GPR2_WE}, 64'd1);
        step();
        DC_WR_ACK = 1'b0;
        chk("mem_retired", {32'd0, RETIRED_COUNT}, exp_retired);
        chk("mem_req_drop", {63'd0, DC_WR_REQ}, 64'd0);

        // REPNE CMPS with C = 5, 4, 3 and ZF = 0, then ZF = 1 terminates
        for (int i = 0; i < 3; i++) begin
            u = '{default: '0};
            u.v = 1'b1; u.ld = 7'b0010010; u.d3 = 3'd1; u.c = 32'd5 - i;
            u.repne = 1'b1; u.cmps2 = 1'b1;
            push(u, 1'b0);
            drive(u);
            step();
            chk("rep_active", {63'd0, CS_REPNE_INTERNAL_COUNT_WB}, 64'd1);
            chk("rep_saved", {32'd0, saved_count}, 64'd5 - i);
        end
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b0010010; u.d3 = 3'd1; u.c = 32'd2; u.fl = 32'h40;
        u.repne = 1'b1; u.cmps2 = 1'b1;
        push(u, 1'b1);
        drive(u);
        chk("zf_term", {63'd0, wb_repne_terminate_all}, 64'd1);
        step();
        chk("zf_idle", {63'd0, CS_REPNE_INTERNAL_COUNT_WB}, 64'd0);
        chk("zf_saved", {32'd0, saved_count}, 64'd2);

        // Count exhausted: C = 7 enters loop, C = 0 with ZF = 0 terminates
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b0010000; u.c = 32'd7; u.repne = 1'b1; u.cmps2 = 1'b1;
        push(u, 1'b0);
        drive(u);
        u.c = 32'd0;
        push(u, 1'b1);
        drive(u);
        chk("c0_term", {63'd0, wb_repne_terminate_all}, 64'd1);
        step();
        chk("c0_saved", {32'd0, saved_count}, 64'd0);
        chk("c0_idle", {63'd0, CS_REPNE_INTERNAL_COUNT_WB}, 64'd0);

        // Invalid entry with every enable set, plus a stray ACK
        DC_WR_ACK = 1'b1;
        u = '{default: '0};
        u.v = 1'b0; u.ld = 7'b1111111; u.c = 32'd0; u.fl = 32'h40; u.repne = 1'b1;
        u.cmps2 = 1'b1; u.addr = 32'h2000;
        drive(u);
        chk("inv_req", {63'd0, DC_WR_REQ}, 64'd0);
        chk("inv_stall", {63'd0, WB_Stall}, 64'd0);
        chk("inv_term", {63'd0, wb_repne_terminate_all}, 64'd0);
        step();
        DC_WR_ACK = 1'b0;
        chk("inv_retired", {32'd0, RETIRED_COUNT}, exp_retired);

        // CLR while waiting on the dcache: entry discarded, no commit
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b1000001; u.a = 32'hABCD; u.addr = 32'h3000;
        drive(u);
        chk("clrdc_stall_before", {63'd0, WB_Stall}, 64'd1);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        exp_retired = 0;
        chk("clrdc_stall", {63'd0, WB_Stall}, 64'd0);
        chk("clrdc_req", {63'd0, DC_WR_REQ}, 64'd0);
        chk("clrdc_retired", {32'd0, RETIRED_COUNT}, 64'd0);

        // CLR while REPNE loop is active
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b0010000; u.c = 32'd9; u.repne = 1'b1; u.cmps2 = 1'b1;
        push(u, 1'b0);
        drive(u);
        step();
        chk("clrrep_active_before", {63'd0, CS_REPNE_INTERNAL_COUNT_WB}, 64'd1);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        exp_retired = 0;
        chk("clrrep_idle", {63'd0, CS_REPNE_INTERNAL_COUNT_WB}, 64'd0);
        chk("clrrep_saved", {32'd0, saved_count}, 64'd0);
        chk("clrrep_retired", {32'd0, RETIRED_COUNT}, 64'd0);

        // Counting restarts from zero after reset
        u = '{default: '0};
        u.v = 1'b1; u.ld = 7'b1000000; u.d1 = 3'd2; u.a = 32'h99;
        push(u, 1'b0);
        drive(u);
        step();
        chk("post_rst_retired", {32'd0, RETIRED_COUNT}, 64'd1);

        repeat (2) step();
        chk("scoreboard_drained", sb.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
